// File: rtl/tlc_fsm_if.sv
// Signal bundle between the traffic-light controller and its environment
// (tick strobe, latched requests in; lamps, arrows and debug state out).
interface tlc_fsm_if;
  logic       TICK;
  logic       HS;
  logic       FS;
  logic [2:0] HLIGHT;
  logic [2:0] FLIGHT;
  logic       HLEFT;
  logic       FLEFT;
  logic [2:0] STATE;

  modport master (
    input  TICK, HS, FS,
    output HLIGHT, FLIGHT, HLEFT, FLEFT, STATE
  );

  modport slave (
    output TICK, HS, FS,
    input  HLIGHT, FLIGHT, HLEFT, FLEFT, STATE
  );
endinterface

// File: rtl/tlc_fsm.sv
// Highway/farm-road traffic-light sequencer: HG -> HY -> (HL) -> (FL -> FG -> FY) -> HG,
// phase lengths counted in TICK strobes; all lamp outputs are registered.
module tlc_fsm #(
  parameter int unsigned HG_T   = 20,
  parameter int unsigned FG_T   = 10,
  parameter int unsigned YEL_T  = 3,
  parameter int unsigned LEFT_T = 5
) (
  input  logic      MCLK,
  input  logic      RESETN,
  tlc_fsm_if.master tl
);

  typedef enum logic [2:0] {
    HG = 3'd0,
    HY = 3'd1,
    HL = 3'd2,
    FL = 3'd3,
    FG = 3'd4,
    FY = 3'd5
  } state_e;

  localparam logic [7:0] HG_LAST   = 8'(HG_T - 1);
  localparam logic [7:0] FG_LAST   = 8'(FG_T - 1);
  localparam logic [7:0] YEL_LAST  = 8'(YEL_T - 1);
  localparam logic [7:0] LEFT_LAST = 8'(LEFT_T - 1);

  // Kept as a raw code so the unused codes 6/7 remain representable and recoverable.
  logic [2:0] state_q;
  state_e     state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       min_done_q, min_done_d;
  logic [2:0] hlight_q, hlight_d;
  logic [2:0] flight_q, flight_d;
  logic       hleft_q, hleft_d;
  logic       fleft_q, fleft_d;
  logic [7:0] phase_last;
  logic       phase_end;
  logic       req;

  always_ff @(posedge MCLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= HG;
      cnt_q      <= '0;
      min_done_q <= 1'b0;
      hlight_q   <= 3'b001;
      flight_q   <= 3'b100;
      hleft_q    <= 1'b0;
      fleft_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      min_done_q <= min_done_d;
      hlight_q   <= hlight_d;
      flight_q   <= flight_d;
      hleft_q    <= hleft_d;
      fleft_q    <= fleft_d;
    end
  end

  always_comb begin
    phase_last = HG_LAST;
    case (state_q)
      HY, FY:  phase_last = YEL_LAST;
      HL, FL:  phase_last = LEFT_LAST;
      FG:      phase_last = FG_LAST;
      default: phase_last = HG_LAST;
    endcase
    phase_end = tl.TICK && (cnt_q == phase_last);
    req       = tl.HS || tl.FS;

    state_d    = HG;
    cnt_d      = cnt_q;
    min_done_d = min_done_q;

    case (state_q)
      HG:      state_d = ((min_done_q || phase_end) && req) ? HY : HG;
      HY:      state_d = phase_end ? (tl.HS ? HL : FL) : HY;
      HL:      state_d = phase_end ? (tl.FS ? FL : HG) : HL;
      FL:      state_d = phase_end ? FG : FL;
      FG:      state_d = phase_end ? FY : FG;
      FY:      state_d = phase_end ? HG : FY;
      default: state_d = HG;
    endcase

    // In HG the counter parks at HG_T-1 once the minimum green has elapsed.
    if (tl.TICK && !phase_end) cnt_d = cnt_q + 8'd1;
    if (phase_end && (state_q == HG)) min_done_d = 1'b1;
    if (state_d != state_q) begin
      cnt_d      = '0;
      min_done_d = 1'b0;
    end
  end

  always_comb begin
    hlight_d = 3'b100;
    flight_d = 3'b100;
    hleft_d  = 1'b0;
    fleft_d  = 1'b0;
    case (state_d)
      HG:      hlight_d = 3'b001;
      HY:      hlight_d = 3'b010;
      HL:      hleft_d  = 1'b1;
      FL:      fleft_d  = 1'b1;
      FG:      flight_d = 3'b001;
      FY:      flight_d = 3'b010;
      default: hlight_d = 3'b100;
    endcase
  end

  assign tl.STATE  = state_q;
  assign tl.HLIGHT = hlight_q;
  assign tl.FLIGHT = flight_q;
  assign tl.HLEFT  = hleft_q;
  assign tl.FLEFT  = fleft_q;

endmodule

// File: doc/tlc_fsm.md
# tlc_fsm

Traffic-light sequencing controller for the highway/farm-road intersection. Consumes the latched sensor requests `HS` (highway left-turn) and `FS` (farm road) produced by the request-latch register, and drives the highway and farm lamps. It also asserts `HLEFT`/`FLEFT` during the left-turn phases; those signals clear the corresponding latched request. Phase durations are counted in `TICK` pulses (1 Hz strobe from the clock divider).

## Interface
- `HG_T`, 20: minimum highway-green duration, in ticks (≥1)
- `FG_T`, 10: farm-green duration, in ticks (≥1)
- `YEL_T`, 3: yellow duration, highway or farm, in ticks (≥1)
- `LEFT_T`, 5: left-turn arrow duration, in ticks (≥1)
- `MCLK` input 1: system clock, rising edge
- `RESETN` input 1: asynchronous, active-low reset
- `TICK` input 1: one-MCLK-wide timing strobe
- `HS` input 1: latched highway left-turn request
- `FS` input 1: latched farm-road request
- `HLIGHT` output 3: highway lamps {R,Y,G}, one-hot
- `FLIGHT` output 3: farm lamps {R,Y,G}, one-hot
- `HLEFT` output 1: highway left arrow; also clears `HS`
- `FLEFT` output 1: farm left arrow; also clears `FS`
- `STATE` output 3: current state code, for debug

## Operation
- One clock; reset is asynchronous and active-low.
- State codes:
  - HG=0: `HLIGHT`=001, `FLIGHT`=100
  - HY=1: `HLIGHT`=010, `FLIGHT`=100
  - HL=2: `HLIGHT`=100, `FLIGHT`=100, `HLEFT`=1
  - FL=3: `HLIGHT`=100, `FLIGHT`=100, `FLEFT`=1
  - FG=4: `HLIGHT`=100, `FLIGHT`=001
  - FY=5: `HLIGHT`=100, `FLIGHT`=010
  - Codes 6 and 7 are illegal and go to HG on the next edge.
- `HLEFT`/`FLEFT` are 0 in every state other than HL/FL.
- Phase timer: 8-bit counter `cnt`.
  - Cleared on every state entry.
  - Increments on each MCLK edge with `TICK`=1.
  - A timed state (HY, HL, FL, FG, FY) ends on the edge where `TICK`=1 and `cnt`==T−1.
- HG:
  - The minimum period completes at the edge where `TICK`=1 and `cnt`==HG_T−1. At that edge a sticky `min_done` flag is set and `cnt` holds.
  - The state exits to HY on the first edge where `min_done`=1 (or is being set) and `HS|FS`=1. `TICK` is not required for this exit.
  - With no request, HG holds indefinitely.
- HY ends: go to HL if `HS`, else to FL. `FS` was necessarily set to reach HY.
- HL ends: go to FL if `FS`, else to HG.
- FL ends: go to FG. FG ends: go to FY. FY ends: go to HG.
- Requests are sampled only at exit edges.
  - A request arriving mid-phase is served in the next cycle through HG.
  - `HS` remaining 1 during the first cycle of HL (the latch clears one edge late) has no effect.
- `min_done` is cleared on leaving HG.

## Timing
- `STATE`, `HLIGHT`, `FLIGHT`, `HLEFT`, `FLEFT` are all registered.
  - They change on the same MCLK edge as the state transition.
  - No output glitches; no combinational path from input to output.
- Reset values, while `RESETN`=0 and immediately (asynchronous): `STATE`=0 (HG), `HLIGHT`=001, `FLIGHT`=100, `HLEFT`=0, `FLEFT`=0, `cnt`=0, `min_done`=0.
- Reset asserted mid-phase (e.g. in FL) drops `FLEFT`/`HLEFT` without waiting for a clock edge.
- Phase lengths, measured from state entry:
  - Timed states last exactly T `TICK` pulses.
  - The first `TICK` counted is the first one strictly after the entry edge.
- HG exit latency after `min_done`: 1 MCLK from `HS|FS`=1 sampled high.
- `TICK`=0 indefinitely freezes every timed state; lamps remain valid.
- Exactly one lamp bit per road is high in every cycle.
- Highway G/Y and farm G/Y are never asserted together.

## Test plan
- **Reset:** drive `RESETN`=0 mid-FL (`FLEFT`=1).
  - Without a clock edge: `FLEFT`=0, `HLIGHT`=001, `FLIGHT`=100, `STATE`=0.
  - After release, the block stays in HG with no request.
- **Idle:** no requests for 100 ticks → `STATE`=0 throughout and `HLIGHT`=001.
- **HS only**, asserted at tick 3:
  - HG until tick 20, then HY for 3 ticks, HL for 5 ticks with `HLEFT`=1 and both roads red, then HG.
  - Bench request latch clears `HS`.
- **FS only**, raised at tick 40 after `min_done`:
  - `STATE`=1 one MCLK later.
  - Then HY 3 → FL 5 (`FLEFT`=1) → FG 10 → FY 3 → HG.
- **Both requests:** sequence is HG → HY → HL → FL → FG → FY → HG. Both requests are cleared by the end.
- **Tick stall / illegal state:**
  - `TICK` held 0 for 50 cycles in FG → `STATE`=4 holds.
  - Force state 7 → `STATE`=0 on the next edge.
